// File: rtl/fifo_pkg.sv
// fifo_pkg: shared state encodings, latency bounds and clog2 helper for the fifo_sync family.
`default_nettype none

package fifo_pkg;

   typedef enum logic [1:0] {
      ST_WAIT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } rd_state_t;

   localparam int RD_LATENCY_MIN = 1;
   localparam int RD_LATENCY_MAX = 2;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_rd_buf.sv
// fifo_rd_buf: small circular output buffer with head/tail/count, push and pop ports.
`default_nettype none

module fifo_rd_buf
   import fifo_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 3,
   parameter int CNT_W = clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clear,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic [CNT_W-1:0] o_count
);

   localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;

   function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (i_clear) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_tail] <= i_push_data;
            r_tail        <= f_next(r_tail);
         end
         if (i_pop) r_head <= f_next(r_head);
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_head];
   assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a fixed-latency fifo_sync read port into a valid/ready stream.
// Optional FIFO_RD_STREAM_STATS_EN adds saturating pop_count / stall_count outputs.
`default_nettype none

module fifo_rd_stream
   import fifo_pkg::*;
#(
   parameter int FIFO_WIDTH = 32,
   parameter int RD_LATENCY = 2
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               fifo_ready,
   input  logic                               fifo_empty,
   output logic                               fifo_rd_en,
   input  logic [FIFO_WIDTH-1:0]              fifo_rd_data,
   input  logic                               flush,
   output logic                               m_valid,
   output logic [FIFO_WIDTH-1:0]              m_data,
   input  logic                               m_ready,
   output logic [clog2(RD_LATENCY+2)-1:0]     level
`ifdef FIFO_RD_STREAM_STATS_EN
   ,
   output logic [31:0]                        pop_count,
   output logic [31:0]                        stall_count
`endif
);

   localparam int BUF_DEPTH = RD_LATENCY + 1;
   localparam int CNT_W     = clog2(BUF_DEPTH + 1);

   rd_state_t             r_state;
   logic [RD_LATENCY-1:0] r_issue;
   logic [RD_LATENCY-1:0] w_issue_next;
   logic [CNT_W-1:0]      w_count;
   logic [CNT_W-1:0]      w_inflight;
   logic [CNT_W:0]        w_used;
   logic [CNT_W:0]        w_limit;
   logic                  w_return;
   logic                  w_xfer;
   logic                  w_flush_acc;
   logic                  w_push;

   generate
      if (RD_LATENCY == 1) begin : g_shift_one
         assign w_issue_next = fifo_rd_en;
      end else begin : g_shift_multi
         assign w_issue_next = {r_issue[RD_LATENCY-2:0], fifo_rd_en};
      end
   endgenerate

   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++) w_inflight = w_inflight + CNT_W'(r_issue[i]);
   end

   assign w_return    = r_issue[RD_LATENCY-1];
   assign w_xfer      = m_valid & m_ready;
   assign w_flush_acc = (r_state == ST_RUN) & flush;
   assign w_push      = w_return & (r_state == ST_RUN);

   // A word leaving this cycle frees its slot for a pop issued in the same cycle.
   assign w_used     = {1'b0, w_count} + {1'b0, w_inflight};
   assign w_limit    = (CNT_W+1)'(BUF_DEPTH) + {{CNT_W{1'b0}}, w_xfer};
   assign fifo_rd_en = (r_state == ST_RUN) & !fifo_empty & !flush & (w_used < w_limit);

   assign m_valid = (w_count != '0) & (r_state != ST_DRAIN);
   assign level   = w_count;

   fifo_rd_buf #(
      .WIDTH (FIFO_WIDTH),
      .DEPTH (BUF_DEPTH),
      .CNT_W (CNT_W)
   ) u_buf (
      .clk         (clk),
      .rst         (rst),
      .i_clear     (w_flush_acc),
      .i_push      (w_push),
      .i_push_data (fifo_rd_data),
      .i_pop       (w_xfer),
      .o_head      (m_data),
      .o_count     (w_count)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_WAIT;
         r_issue <= '0;
      end else begin
         r_issue <= w_issue_next;
         case (r_state)
            ST_WAIT:  if (fifo_ready) r_state <= ST_RUN;
            ST_RUN:   if (flush) r_state <= ST_DRAIN;
            ST_DRAIN: if (w_issue_next == '0) r_state <= ST_RUN;
            default:  r_state <= ST_WAIT;
         endcase
      end
   end

`ifdef FIFO_RD_STREAM_STATS_EN
   logic [31:0] r_pop_count;
   logic [31:0] r_stall_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pop_count   <= '0;
         r_stall_count <= '0;
      end else if (w_flush_acc) begin
         r_pop_count   <= '0;
         r_stall_count <= '0;
      end else begin
         if (w_xfer && (r_pop_count != '1)) r_pop_count <= r_pop_count + 32'd1;
         if (m_valid && !m_ready && (r_stall_count != '1)) r_stall_count <= r_stall_count + 32'd1;
      end
   end

   assign pop_count   = r_pop_count;
   assign stall_count = r_stall_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed table plus corner-case sequences against a fixed-latency FIFO model.
`default_nettype none

module tb_fifo_rd_stream;
   import fifo_pkg::*;

   parameter int TB_RD_LATENCY = 2;
   localparam int L  = TB_RD_LATENCY;
   localparam int LW = clog2(L + 2);

   logic          clk = 1'b0;
   logic          rst;
   logic          fifo_ready;
   logic          fifo_empty;
   logic          fifo_rd_en;
   logic [31:0]   fifo_rd_data;
   logic          flush;
   logic          m_valid;
   logic [31:0]   m_data;
   logic          m_ready;
   logic [LW-1:0] level;
`ifdef FIFO_RD_STREAM_STATS_EN
   logic [31:0]   pop_count;
   logic [31:0]   stall_count;
`endif

   fifo_rd_stream #(.FIFO_WIDTH(32), .RD_LATENCY(L)) dut (
      .clk          (clk),
      .rst          (rst),
      .fifo_ready   (fifo_ready),
      .fifo_empty   (fifo_empty),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_rd_data (fifo_rd_data),
      .flush        (flush),
      .m_valid      (m_valid),
      .m_data       (m_data),
      .m_ready      (m_ready),
      .level        (level)
`ifdef FIFO_RD_STREAM_STATS_EN
      ,
      .pop_count    (pop_count),
      .stall_count  (stall_count)
`endif
   );

   always #5 clk = ~clk;

   // Synchronous FIFO model with L cycles of read latency.
   logic [31:0] fmem [0:255];
   int          fwr;
   int          frd;
   logic [31:0] d1;
   logic        tog;
   logic        tog_en;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         frd          <= 0;
         d1           <= '0;
         fifo_rd_data <= '0;
         tog          <= 1'b0;
      end else begin
         tog <= tog_en & ~tog;
         if (fifo_rd_en) frd <= frd + 1;
         if (L == 1) begin
            if (fifo_rd_en) fifo_rd_data <= fmem[frd[7:0]];
         end else begin
            if (fifo_rd_en) d1 <= fmem[frd[7:0]];
            fifo_rd_data <= d1;
         end
      end
   end

   assign fifo_empty = (fwr == frd) | tog;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n, input logic [31:0] base, input logic rand_words);
      @(posedge clk);
      #1;
      rst        = 1'b0;
      fifo_ready = 1'b0;
      flush      = 1'b0;
      m_ready    = 1'b0;
      tog_en     = 1'b0;
      for (int i = 0; i < n; i++) fmem[i] = rand_words ? $urandom : base + 32'(i);
      fwr = n;
      next_cycle();
      next_cycle();
      rst = 1'b1;
   endtask

   typedef struct {
      logic          fifo_ready;
      logic          m_ready;
      logic          exp_rd_en;
      logic          exp_valid;
      logic [31:0]   exp_data;
      logic [LW-1:0] exp_level;
   } vec_t;

   vec_t vecs [15];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] got_q [$];
      logic [31:0] exp_w;
      int          cyc;
      int          viol;
      int          unstable;
      logic        pv;
      logic        pr;
      logic [31:0] pd;

      // Reset release: 6 cycles of fifo_ready low, then 3 words drained with m_ready high.
      for (int c = 0; c < 15; c++) begin
         int k;
         k = c - 6;
         vecs[c].fifo_ready = (c >= 6);
         vecs[c].m_ready    = 1'b1;
         vecs[c].exp_rd_en  = (k >= 1) && (k <= 3);
         vecs[c].exp_valid  = (k >= 2 + L) && (k <= 4 + L);
         vecs[c].exp_data   = vecs[c].exp_valid ? 32'hA5A5_0001 + 32'(k - 2 - L) : 32'h0;
         vecs[c].exp_level  = vecs[c].exp_valid ? LW'(1) : LW'(0);
      end

      rst = 1'b1; fifo_ready = 1'b0; flush = 1'b0; m_ready = 1'b0; tog_en = 1'b0; fwr = 0;
      do_reset(3, 32'hA5A5_0001, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      check("reset_rd_en", {31'b0, fifo_rd_en}, 32'd0);
      check("reset_m_valid", {31'b0, m_valid}, 32'd0);
      check("reset_m_data", m_data, 32'd0);
      check("reset_level", 32'(level), 32'd0);
      next_cycle();
      rst = 1'b1;

      // Level staying at 1 while data streams covers simultaneous return and accept.
      for (int i = 0; i < 15; i++) begin
         fifo_ready = vecs[i].fifo_ready;
         m_ready    = vecs[i].m_ready;
         @(negedge clk);
         check($sformatf("vec%0d_rd_en", i), {31'b0, fifo_rd_en}, {31'b0, vecs[i].exp_rd_en});
         check($sformatf("vec%0d_m_valid", i), {31'b0, m_valid}, {31'b0, vecs[i].exp_valid});
         check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
         if (vecs[i].exp_valid) check($sformatf("vec%0d_m_data", i), m_data, vecs[i].exp_data);
         next_cycle();
      end

      // Backpressure: 8 words, 10 stall cycles, then burst out with no gap.
      do_reset(8, 32'hB000_0001, 1'b0);
      fifo_ready = 1'b1;
      m_ready    = 1'b0;
      cyc = 0;
      @(negedge clk);
      while (!m_valid && cyc < 20) begin
         next_cycle();
         @(negedge clk);
         cyc++;
      end
      check("bp_first_valid", {31'b0, m_valid}, 32'd1);
      for (int i = 0; i < 9; i++) begin
         next_cycle();
         @(negedge clk);
      end
      check("bp_level_full", 32'(level), 32'(L + 1));
      check("bp_head_held", m_data, 32'hB000_0001);
      check("bp_no_pop_full", {31'b0, fifo_rd_en}, 32'd0);
      next_cycle();
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check($sformatf("bp_out%0d_valid", i), {31'b0, m_valid}, 32'd1);
         check($sformatf("bp_out%0d_data", i), m_data, 32'hB000_0001 + 32'(i));
         next_cycle();
      end
      @(negedge clk);
      check("bp_drained", {31'b0, m_valid}, 32'd0);
`ifdef FIFO_RD_STREAM_STATS_EN
      check("stats_pop_count", pop_count, 32'd8);
      check("stats_stall_count", stall_count, 32'd10);
`endif
      next_cycle();

      // Flush while the buffer is full of one stored word plus in-flight returns.
      do_reset(6, 32'hC000_0001, 1'b0);
      fifo_ready = 1'b1;
      m_ready    = 1'b0;
      cyc = 0;
      @(negedge clk);
      while (!m_valid && cyc < 20) begin
         next_cycle();
         @(negedge clk);
         cyc++;
      end
      check("fl_first_valid", {31'b0, m_valid}, 32'd1);
      check("fl_first_data", m_data, 32'hC000_0001);
      next_cycle();
      flush = 1'b1;
      @(negedge clk);
      check("fl_no_pop_on_flush", {31'b0, fifo_rd_en}, 32'd0);
      next_cycle();
      flush = 1'b0;
      @(negedge clk);
      check("fl_valid_low", {31'b0, m_valid}, 32'd0);
      next_cycle();
      m_ready = 1'b1;
      got_q.delete();
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (m_valid && m_ready) got_q.push_back(m_data);
         next_cycle();
      end
      check("fl_word_count", 32'(got_q.size()), 32'(6 - (L + 1)));
      for (int i = 0; i < got_q.size() && i < 6; i++)
         check($sformatf("fl_word%0d", i), got_q[i], 32'hC000_0001 + 32'(L + 1 + i));

      // fifo_empty toggling every cycle with random backpressure over 100 random words.
      do_reset(100, 32'h0, 1'b1);
      fifo_ready = 1'b1;
      tog_en     = 1'b1;
      got_q.delete();
      viol = 0; unstable = 0; cyc = 0;
      pv = 1'b0; pr = 1'b0; pd = '0;
      while (got_q.size() < 100 && cyc < 3000) begin
         m_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (fifo_rd_en && fifo_empty) viol++;
         if (pv && !pr && (!m_valid || m_data !== pd)) unstable++;
         if (m_valid && m_ready) got_q.push_back(m_data);
         pv = m_valid; pr = m_ready; pd = m_data;
         next_cycle();
         cyc++;
      end
      m_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (fifo_rd_en && fifo_empty) viol++;
         if (m_valid && m_ready) got_q.push_back(m_data);
         next_cycle();
      end
      check("rnd_word_count", 32'(got_q.size()), 32'd100);
      check("rnd_pop_while_empty", 32'(viol), 32'd0);
      check("rnd_unstable_output", 32'(unstable), 32'd0);
      for (int i = 0; i < 100 && i < got_q.size(); i++) begin
         exp_w = fmem[i];
         check($sformatf("rnd_word%0d", i), got_q[i], exp_w);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
